// File: rtl/reg_file_sb.sv
// Integer register file with write-to-read bypass, pending-write scoreboard,
// and a registered monitor copy of every accepted read and write.
module reg_file_sb #(
  parameter int REG_NUM_WIDTH = 5,
  parameter int REG_WIDTH     = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rdEn,
  input  logic [REG_NUM_WIDTH-1:0] rdAddr,
  input  logic [REG_WIDTH-1:0]     rdData,
  input  logic                     rs1En,
  input  logic [REG_NUM_WIDTH-1:0] rs1Addr,
  input  logic                     rs2En,
  input  logic [REG_NUM_WIDTH-1:0] rs2Addr,
  output logic [REG_WIDTH-1:0]     rs1Data,
  output logic [REG_WIDTH-1:0]     rs2Data,
  input  logic                     reserveEn,
  input  logic [REG_NUM_WIDTH-1:0] reserveAddr,
  output logic                     stall,
  output logic                     monRdEn,
  output logic [REG_NUM_WIDTH-1:0] monRdAddr,
  output logic [REG_WIDTH-1:0]     monRdData,
  output logic                     monRs1En,
  output logic [REG_NUM_WIDTH-1:0] monRs1Addr,
  output logic                     monRs2En,
  output logic [REG_NUM_WIDTH-1:0] monRs2Addr
);

  localparam int NREG = 1 << REG_NUM_WIDTH;

  logic [REG_WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]      busy;

  logic                 wr_hit_p0;
  logic                 rs1_acc_p0;
  logic                 rs2_acc_p0;
  logic [REG_WIDTH-1:0] rs1_val_p0;
  logic [REG_WIDTH-1:0] rs2_val_p0;

  // A writeback landing this cycle resolves the hazard on its own index.
  function automatic logic eff_busy(input logic [NREG-1:0]          b,
                                    input logic [REG_NUM_WIDTH-1:0] a,
                                    input logic                     w,
                                    input logic [REG_NUM_WIDTH-1:0] wa);
    return b[a] & ~(w && (wa == a));
  endfunction

  // Stage p0: hazard detection and operand selection
  always_comb begin
    wr_hit_p0  = rdEn && (rdAddr != '0);
    stall      = (rs1En && eff_busy(busy, rs1Addr, wr_hit_p0, rdAddr)) ||
                 (rs2En && eff_busy(busy, rs2Addr, wr_hit_p0, rdAddr));
    rs1_acc_p0 = rs1En && !stall;
    rs2_acc_p0 = rs2En && !stall;

    rs1_val_p0 = regs[rs1Addr];
    if (wr_hit_p0 && (rdAddr == rs1Addr)) rs1_val_p0 = rdData;
    if (rs1Addr == '0) rs1_val_p0 = '0;

    rs2_val_p0 = regs[rs2Addr];
    if (wr_hit_p0 && (rdAddr == rs2Addr)) rs2_val_p0 = rdData;
    if (rs2Addr == '0) rs2_val_p0 = '0;
  end

  // Stage p1: architectural state update
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_hit_p0) begin
      regs[rdAddr] <= rdData;
    end
  end

  // Reserve is applied after the clear so a new producer outranks the retiring one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      if (wr_hit_p0) busy[rdAddr] <= 1'b0;
      if (reserveEn && (reserveAddr != '0)) busy[reserveAddr] <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rs1Data <= '0;
      rs2Data <= '0;
    end else begin
      if (rs1_acc_p0) rs1Data <= rs1_val_p0;
      if (rs2_acc_p0) rs2Data <= rs2_val_p0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      monRdEn    <= 1'b0;
      monRdAddr  <= '0;
      monRdData  <= '0;
      monRs1En   <= 1'b0;
      monRs1Addr <= '0;
      monRs2En   <= 1'b0;
      monRs2Addr <= '0;
    end else begin
      monRdEn  <= wr_hit_p0;
      monRs1En <= rs1_acc_p0;
      monRs2En <= rs2_acc_p0;
      if (wr_hit_p0) begin
        monRdAddr <= rdAddr;
        monRdData <= rdData;
      end
      if (rs1_acc_p0) monRs1Addr <= rs1Addr;
      if (rs2_acc_p0) monRs2Addr <= rs2Addr;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed table-driven bench for reg_file_sb: reads, writes, bypass,
// scoreboard stalls and mid-operation reset.
module tb_reg_file_sb;

  logic        clock = 1'b0;
  logic        reset;
  logic        rdEn;
  logic [4:0]  rdAddr;
  logic [31:0] rdData;
  logic        rs1En, rs2En;
  logic [4:0]  rs1Addr, rs2Addr;
  logic [31:0] rs1Data, rs2Data;
  logic        reserveEn;
  logic [4:0]  reserveAddr;
  logic        stall;
  logic        monRdEn;
  logic [4:0]  monRdAddr;
  logic [31:0] monRdData;
  logic        monRs1En, monRs2En;
  logic [4:0]  monRs1Addr, monRs2Addr;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  reg_file_sb #(.REG_NUM_WIDTH(5), .REG_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rdData),
    .rs1En(rs1En), .rs1Addr(rs1Addr), .rs2En(rs2En), .rs2Addr(rs2Addr),
    .rs1Data(rs1Data), .rs2Data(rs2Data),
    .reserveEn(reserveEn), .reserveAddr(reserveAddr), .stall(stall),
    .monRdEn(monRdEn), .monRdAddr(monRdAddr), .monRdData(monRdData),
    .monRs1En(monRs1En), .monRs1Addr(monRs1Addr),
    .monRs2En(monRs2En), .monRs2Addr(monRs2Addr)
  );

  typedef struct {
    logic        wen;  logic [4:0] wa;  logic [31:0] wd;
    logic        r1en; logic [4:0] r1a;
    logic        r2en; logic [4:0] r2a;
    logic        ren;  logic [4:0] ra;
    logic        e_stall;
    logic [31:0] e_rs1, e_rs2;
    logic        e_mrd, e_m1, e_m2;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    rdEn = 0; rdAddr = 0; rdData = 0;
    rs1En = 0; rs1Addr = 0; rs2En = 0; rs2Addr = 0;
    reserveEn = 0; reserveAddr = 0;
  endtask

  function automatic vec_t mk(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                              input logic r1en, input logic [4:0] r1a,
                              input logic r2en, input logic [4:0] r2a,
                              input logic ren, input logic [4:0] ra,
                              input logic es, input logic [31:0] e1, input logic [31:0] e2,
                              input logic emrd, input logic em1, input logic em2);
    vec_t v;
    v.wen = wen; v.wa = wa; v.wd = wd; v.r1en = r1en; v.r1a = r1a;
    v.r2en = r2en; v.r2a = r2a; v.ren = ren; v.ra = ra;
    v.e_stall = es; v.e_rs1 = e1; v.e_rs2 = e2; v.e_mrd = emrd; v.e_m1 = em1; v.e_m2 = em2;
    return v;
  endfunction

  initial begin
    //            wen wa  wd            r1 a   r2 a   rsv a  stall rs1           rs2           mrd m1 m2
    vecs[0]  = mk(0, 0,  32'h0,        1, 5,  1, 0,  0, 0,  0, 32'h0,        32'h0,        0, 1, 1);
    vecs[1]  = mk(1, 3,  32'hDEADBEEF, 0, 0,  0, 0,  0, 0,  0, 32'h0,        32'h0,        1, 0, 0);
    vecs[2]  = mk(0, 0,  32'h0,        1, 3,  0, 0,  0, 0,  0, 32'hDEADBEEF, 32'h0,        0, 1, 0);
    vecs[3]  = mk(1, 0,  32'h1234,     0, 0,  1, 3,  0, 0,  0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1);
    vecs[4]  = mk(0, 0,  32'h0,        0, 0,  1, 0,  0, 0,  0, 32'hDEADBEEF, 32'h0,        0, 0, 1);
    vecs[5]  = mk(1, 7,  32'hA5A5A5A5, 0, 0,  1, 7,  0, 0,  0, 32'hDEADBEEF, 32'hA5A5A5A5, 1, 0, 1);
    vecs[6]  = mk(0, 0,  32'h0,        0, 0,  0, 0,  1, 9,  0, 32'hDEADBEEF, 32'hA5A5A5A5, 0, 0, 0);
    vecs[7]  = mk(0, 0,  32'h0,        1, 9,  1, 7,  0, 0,  1, 32'hDEADBEEF, 32'hA5A5A5A5, 0, 0, 0);
    vecs[8]  = mk(1, 9,  32'h55,       1, 9,  0, 0,  0, 0,  0, 32'h55,       32'hA5A5A5A5, 1, 1, 0);
    vecs[9]  = mk(0, 0,  32'h0,        1, 9,  0, 0,  0, 0,  0, 32'h55,       32'hA5A5A5A5, 0, 1, 0);
    vecs[10] = mk(1, 4,  32'h10,       0, 0,  0, 0,  1, 4,  0, 32'h55,       32'hA5A5A5A5, 1, 0, 0);
    vecs[11] = mk(0, 0,  32'h0,        0, 0,  1, 4,  0, 0,  1, 32'h55,       32'hA5A5A5A5, 0, 0, 0);
    vecs[12] = mk(1, 4,  32'h10,       0, 0,  0, 0,  0, 0,  0, 32'h55,       32'hA5A5A5A5, 1, 0, 0);
    vecs[13] = mk(0, 0,  32'h0,        0, 0,  1, 4,  0, 0,  0, 32'h55,       32'h10,       0, 0, 1);

    idle();
    reset = 0;
    repeat (2) @(negedge clock);
    chk("reset_rs1Data", rs1Data, 32'h0);
    chk("reset_monRdEn", {31'h0, monRdEn}, 32'h0);
    chk("reset_stall", {31'h0, stall}, 32'h0);
    reset = 1;

    for (int i = 0; i < 14; i++) begin
      rdEn = vecs[i].wen; rdAddr = vecs[i].wa; rdData = vecs[i].wd;
      rs1En = vecs[i].r1en; rs1Addr = vecs[i].r1a;
      rs2En = vecs[i].r2en; rs2Addr = vecs[i].r2a;
      reserveEn = vecs[i].ren; reserveAddr = vecs[i].ra;
      #1;
      chk($sformatf("v%0d_stall", i), {31'h0, stall}, {31'h0, vecs[i].e_stall});
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_rs1Data", i), rs1Data, vecs[i].e_rs1);
      chk($sformatf("v%0d_rs2Data", i), rs2Data, vecs[i].e_rs2);
      chk($sformatf("v%0d_monRdEn", i), {31'h0, monRdEn}, {31'h0, vecs[i].e_mrd});
      chk($sformatf("v%0d_monRs1En", i), {31'h0, monRs1En}, {31'h0, vecs[i].e_m1});
      chk($sformatf("v%0d_monRs2En", i), {31'h0, monRs2En}, {31'h0, vecs[i].e_m2});
      if (vecs[i].e_mrd) begin
        chk($sformatf("v%0d_monRdAddr", i), {27'h0, monRdAddr}, {27'h0, vecs[i].wa});
        chk($sformatf("v%0d_monRdData", i), monRdData, vecs[i].wd);
      end
      if (vecs[i].e_m1) chk($sformatf("v%0d_monRs1Addr", i), {27'h0, monRs1Addr}, {27'h0, vecs[i].r1a});
      if (vecs[i].e_m2) chk($sformatf("v%0d_monRs2Addr", i), {27'h0, monRs2Addr}, {27'h0, vecs[i].r2a});
      @(negedge clock);
      idle();
    end

    // Mid-operation reset: pending reserve on x2 and in-flight data discarded.
    reserveEn = 1; reserveAddr = 2;
    @(negedge clock);
    idle();
    rs2En = 1; rs2Addr = 2;
    #1;
    chk("pre_reset_x2_stall", {31'h0, stall}, 32'h1);
    rs2En = 0; rs2Addr = 0;
    reset = 0;
    #1;
    chk("midrst_rs1Data", rs1Data, 32'h0);
    chk("midrst_rs2Data", rs2Data, 32'h0);
    chk("midrst_mon", {monRdEn, monRs1En, monRs2En}, 3'b000);
    chk("midrst_monRdData", monRdData, 32'h0);
    chk("midrst_stall", {31'h0, stall}, 32'h0);
    @(negedge clock);
    reset = 1;
    rs2En = 1; rs2Addr = 2;
    rs1En = 1; rs1Addr = 3;
    #1;
    chk("postrst_x2_stall", {31'h0, stall}, 32'h0);
    @(posedge clock);
    #1;
    chk("postrst_rs2Data", rs2Data, 32'h0);
    chk("postrst_rs1Data_x3_cleared", rs1Data, 32'h0);
    chk("postrst_monRs2En", {31'h0, monRs2En}, 32'h1);
    chk("postrst_monRs2Addr", {27'h0, monRs2Addr}, 32'h2);
    @(negedge clock);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Architectural integer register file for the RISC-V core, with write-to-read bypass and a pending-write scoreboard. It sits between decode/writeback and the DPI-C register monitor: it services operand reads and writeback writes, raises a stall on read-after-write hazards, and emits a registered copy of every accepted access on its monitor port.

## Interface
- REG_NUM_WIDTH, 5, register index width (32 registers)
- REG_WIDTH, 32, register data width
- clock  in  1  single clock, all state updates on posedge
- reset  in  1  asynchronous, active-low; asserting it clears all state immediately
- rdEn  in  1  writeback write request
- rdAddr  in  REG_NUM_WIDTH  write index
- rdData  in  REG_WIDTH  write data
- rs1En, rs2En  in  1  operand read requests
- rs1Addr, rs2Addr  in  REG_NUM_WIDTH  read indices
- rs1Data, rs2Data  out  REG_WIDTH  read data, registered
- reserveEn  in  1  decode marks rd as pending (issued producer)
- reserveAddr  in  REG_NUM_WIDTH  index to mark pending
- stall  out  1  combinational read-after-write hazard flag
- monRdEn, monRdAddr, monRdData  out  1/REG_NUM_WIDTH/REG_WIDTH  registered accepted write
- monRs1En, monRs1Addr, monRs2En, monRs2Addr  out  1/REG_NUM_WIDTH  registered accepted reads

## Operation
- Storage: 2^REG_NUM_WIDTH entries; entry 0 reads 0 always, writes to index 0 discarded (no storage update, no monitor write event).
- Write: rdEn with rdAddr≠0 updates entry at posedge; also clears busy[rdAddr].
- Scoreboard: busy bit per entry. reserveEn with reserveAddr≠0 sets busy[reserveAddr]. Same-cycle reserve and write to same index: busy ends 1 (new producer wins). busy[0] constant 0.
- Hazard: effBusy(a) = busy[a] & !(rdEn & rdAddr==a). stall = (rs1En & effBusy(rs1Addr)) | (rs2En & effBusy(rs2Addr)).
- Read accepted when rsNEn & !stall. Accepted read captures data into rsNData; both ports suppressed while stall is high (rsNData hold previous value).
- Bypass: accepted read of index equal to a same-cycle rdAddr (≠0, rdEn) captures rdData, not stale storage.
- Reads not enabled: rsNData hold.
- Monitor: every posedge, monRdEn ← rdEn & rdAddr≠0; monRsNEn ← rsNEn & !stall; addr/data fields registered alongside (hold when enable 0).
- Writes are never blocked by stall.

## Timing
- Reset (asynchronous assertion, synchronous release at next edge): all entries 0, all busy 0, rs1Data=rs2Data=0, all mon* = 0, stall=0 (no enables during reset assumed by upstream; stall still derived from cleared busy).
- Read latency 1 cycle: request at edge N, rsNData valid after edge N.
- Write visible to storage after edge; visible to a same-cycle read via bypass.
- stall is combinational from inputs and busy; no registered delay.
- Monitor outputs lag their source events by exactly 1 cycle.
- Reset mid-operation: pending busy bits and in-flight read data discarded; first cycle after release behaves as empty scoreboard.

## Test plan
- Reset then read x5 and x0 with rs1En/rs2En -> after 1 cycle rs1Data=0, rs2Data=0, monRs1En=monRs2En=1, stall=0.
- Write x3=0xDEADBEEF, next cycle read rs1=x3 -> rs1Data=0xDEADBEEF; write x0=0x1234 then read x0 -> 0, monRdEn stays 0 for x0 write.
- Same-cycle write x7=0xA5A5A5A5 and read rs2=x7 -> rs2Data=0xA5A5A5A5 next cycle, stall=0.
- Reserve x9, next cycle read rs1=x9 -> stall=1, rs1Data holds, monRs1En=0; write x9=0x55 with read still requested -> stall=0 that cycle, rs1Data=0x55.
- Reserve x4 and write x4=0x10 in same cycle, next cycle read x4 -> stall=1 (busy retained), storage holds 0x10 after later unreserved read.
- Reserve x2, assert reset mid-operation, release, read x2 -> stall=0, rs2Data=0, all mon* were 0 during reset.
